// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, RISC-V load/store width codes and the alignment check.
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  function automatic logic access_err(input logic [2:0] f3, input logic [2:0] a);
    return f3 == 3'b111 || (f3 inside {F3_H, F3_HU} && a[0]) ||
           (f3 inside {F3_W, F3_WU} && a[1:0] != 2'b00) || (f3 == F3_D && a != 3'b000);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request and data-memory signals of the load/store unit.
interface lsu_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] load_data;
  logic        busy;
  logic        done;
  logic        err;
  modport slave (input start, is_store, funct3, addr, store_data, mem_rdata,
                 output mem_addr, mem_wr, mem_wdata, load_data, busy, done, err);
  modport master (output start, is_store, funct3, addr, store_data, mem_rdata,
                  input mem_addr, mem_wr, mem_wdata, load_data, busy, done, err);
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: extracts/extends a load lane and merges store bytes into a doubleword.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] sdata_i,
  output logic [63:0] ldata_o,
  output logic [63:0] wdata_o
);
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] rw;
  logic [7:0]  bm;
  logic [63:0] mask;
  logic        sg;
  logic        is_b, is_h, is_w;
  assign is_b = f3_i inside {F3_B, F3_BU};
  assign is_h = f3_i inside {F3_H, F3_HU};
  assign is_w = f3_i inside {F3_W, F3_WU};
  assign sg   = !(f3_i inside {F3_BU, F3_HU, F3_WU});
  assign rb   = 8'(rdata_i >> {off_i, 3'b000});
  assign rh   = 16'(rdata_i >> {off_i[2:1], 4'b0000});
  assign rw   = 32'(rdata_i >> {off_i[2], 5'b00000});
  assign ldata_o = is_b ? {{56{sg & rb[7]}}, rb} :
                   is_h ? {{48{sg & rh[15]}}, rh} :
                   is_w ? {{32{sg & rw[31]}}, rw} : rdata_i;
  // byte-enable mask of the addressed lanes, expanded to bit granularity
  assign bm = (is_b ? 8'h01 : is_h ? 8'h03 : is_w ? 8'h0F : 8'hFF) << off_i;
  for (genvar g = 0; g < 8; g++) begin : g_mask
    assign mask[8*g +: 8] = {8{bm[g]}};
  end
  assign wdata_o = (rdata_i & ~mask) | ((sdata_i << {off_i, 3'b000}) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RISC-V load/store sequencer with read-modify-write
// for sub-doubleword stores and early error completion for bad accesses.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  state_e      state_q, state_d;
  logic        st_q, st_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [63:0] addr_q, addr_d, sdata_q, sdata_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [63:0] lane_ld, lane_wd;
  logic        take, bad;
  assign take = state_q == IDLE && bus.start;
  assign bad  = access_err(bus.funct3, bus.addr[2:0]);
  lsu_lane u_lane (
    .f3_i   (f3_q),
    .off_i  (addr_q[2:0]),
    .rdata_i(bus.mem_rdata),
    .sdata_i(sdata_q),
    .ldata_o(lane_ld),
    .wdata_o(lane_wd)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !bus.start ? IDLE : bad ? DONE :
                         (bus.is_store && bus.funct3 == F3_D) ? WRITE : READ;
      READ:    state_d = CAPT;
      CAPT:    state_d = st_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // sd skips the read phase, so its write word is loaded straight from store_data
  always_comb begin
    st_d    = take ? bus.is_store : st_q;
    f3_d    = take ? bus.funct3 : f3_q;
    addr_d  = take ? bus.addr : addr_q;
    sdata_d = take ? bus.store_data : sdata_q;
    err_d   = take ? bad : err_q;
    wdata_d = take ? bus.store_data : (state_q == CAPT && st_q) ? lane_wd : wdata_q;
    ld_d    = (state_q == CAPT && !st_q) ? lane_ld : ld_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 64'd0;
      sdata_q <= 64'd0;
      err_q   <= 1'b0;
      wdata_q <= 64'd0;
      ld_q    <= 64'd0;
    end else begin
      st_q    <= st_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end
  always_comb begin
    bus.busy      = state_q != IDLE;
    bus.done      = state_q == DONE;
    bus.err       = state_q == DONE && err_q;
    bus.mem_wr    = state_q == WRITE;
    bus.mem_addr  = {addr_q[63:3], 3'b000};
    bus.mem_wdata = wdata_q;
    bus.load_data = ld_q;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The clock SHALL be port clk, input, 1 bit, and state SHALL change only on its rising edge.
REQ-003 The reset SHALL be port rst, input, 1 bit, asynchronous, active-low (0 = reset).
REQ-004 start  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load; latched on start.
REQ-006 funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; latched on start.
REQ-007 addr  in  64  byte address (ALU result); latched on start.
REQ-008 store_data  in  64  register B value; latched on start.
REQ-009 mem_addr  out  64  doubleword address to data memory, equal to {addr_q[63:3],3'b000}.
REQ-010 mem_wr  out  1  memory write enable, one cycle per store.
REQ-011 mem_wdata  out  64  merged write doubleword.
REQ-012 mem_rdata  in  64  memory read data, valid the cycle after mem_addr is presented with mem_wr=0.
REQ-013 load_data  out  64  extended load result, registered, held until the next load completes.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  qualified by done; misaligned access or funct3=111.

Function
REQ-017 The FSM states SHALL be IDLE, READ, CAPT, WRITE, DONE.
REQ-018 IDLE -> start=1 -> DONE with err=1 if the access is misaligned or funct3=111.
REQ-019 An access SHALL be misaligned when addr[0]≠0 for h, addr[1:0]≠0 for w, or addr[2:0]≠0 for d.
REQ-020 IDLE -> start=1, valid sd -> WRITE; valid load or sb/sh/sw -> READ.
REQ-021 READ SHALL drive mem_addr with mem_wr=0 and SHALL always go to CAPT.
REQ-022 In CAPT a load SHALL register load_data and go to DONE.
REQ-023 In CAPT a store SHALL register the merged word (mem_rdata with the addressed lanes replaced by store_data low bytes) and go to WRITE.
REQ-024 WRITE SHALL assert mem_wr=1 with mem_wdata for exactly one cycle, then go to DONE.
REQ-025 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-026 Load extraction SHALL take byte lane addr[2:0], half lane addr[2:1], or word lane addr[2].
REQ-027 b, h and w loads SHALL sign-extend; bu, hu and wu SHALL zero-extend; d SHALL pass 64 bits unchanged.
REQ-028 Latency from start to done SHALL be 3 cycles for a load, 2 cycles for sd, 4 cycles for sb/sh/sw, and 1 cycle for an err access.
REQ-029 start SHALL be ignored while busy=1, with no latch and no effect.
REQ-030 An err access SHALL never assert mem_wr and SHALL leave load_data unchanged.
REQ-031 mem_wr SHALL be 0 in all states except WRITE.

Reset
REQ-032 While rst=0 the state SHALL be IDLE and busy, done, err and mem_wr SHALL be 0.
REQ-033 While rst=0, load_data, mem_wdata, all latched inputs and the merge register SHALL be 0.
REQ-034 Reset asserted mid-operation, including in WRITE, SHALL drop mem_wr immediately and abort without a done pulse.

Structure
REQ-035 Package lsu_pkg SHALL hold the state enum and the funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
REQ-036 The combinational lane extract/merge logic SHALL be one sub-module, lsu_lane.

Verification
REQ-037 Preload memory 0x100 = 0x8877665544332211, ld addr=0x100 -> done at cycle 3, load_data=0x8877665544332211, err=0.
REQ-038 Same memory, lb addr=0x107 -> load_data=0xFFFFFFFFFFFFFF88; lbu addr=0x107 -> load_data=0x88.
REQ-039 Same memory, sh addr=0x102 with store_data=0xABCD -> one mem_wr cycle, mem_wdata=0x88776655ABCD2211, done at cycle 4.
REQ-040 sw addr=0x102 -> done at cycle 1, err=1, mem_wr never asserted, load_data unchanged.
REQ-041 Issue a load, pulse start again at cycle 1 with is_store=1 -> the second start is ignored and exactly one done is seen.
REQ-042 sd in WRITE with rst driven low mid-cycle -> mem_wr falls asynchronously, state is IDLE, and no done pulse is seen.
